// File: rtl/hub75_scan_driver.sv
// HUB75 32x32 scan driver: fetches pixels, shifts bit planes, latches and lights row pairs (BCM).
// Optional HUB75_BRIGHTNESS_EN adds a brightness input that trims the oe-low window inside DISPLAY.
module hub75_scan_driver #(
    parameter int unsigned COLS       = 32,
    parameter int unsigned ROW_PAIRS  = 16,
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned BASE_ON    = 64
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                                brightness,
`endif
    output logic                                      fb_rd_en,
    output logic [$clog2(ROW_PAIRS)+$clog2(COLS)-1:0] fb_rd_addr,
    input  logic [6*COLOR_BITS-1:0]                   fb_rd_data,
    output logic                                      r1,
    output logic                                      g1,
    output logic                                      b1,
    output logic                                      r2,
    output logic                                      g2,
    output logic                                      b2,
    output logic                                      a,
    output logic                                      b,
    output logic                                      c,
    output logic                                      d,
    output logic                                      mclk,
    output logic                                      lat,
    output logic                                      oe,
    output logic                                      frame_done
);

    localparam int unsigned ROW_W    = $clog2(ROW_PAIRS);
    localparam int unsigned COL_W    = $clog2(COLS);
    localparam int unsigned PLANE_W  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int unsigned DISP_MAX = BASE_ON << (COLOR_BITS - 1);
    localparam int unsigned CNT_W    = $clog2(((DISP_MAX > CLK_DIV) ? DISP_MAX : CLK_DIV) + 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_PAIRS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOR_BITS - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_out_q, row_out_d;
    logic [5:0]         pix_q, pix_d;
    logic               frame_done_q, frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
    logic [CNT_W-1:0]   on_q, on_d;
    logic [CNT_W+7:0]   on_prod;
`endif

    logic [CNT_W-1:0]      disp_len;
    logic [CNT_W-1:0]      disp_last;
    logic [COLOR_BITS-1:0] ch_r1, ch_g1, ch_b1, ch_r2, ch_g2, ch_b2;

    assign ch_r1 = fb_rd_data[6*COLOR_BITS-1 -: COLOR_BITS];
    assign ch_g1 = fb_rd_data[5*COLOR_BITS-1 -: COLOR_BITS];
    assign ch_b1 = fb_rd_data[4*COLOR_BITS-1 -: COLOR_BITS];
    assign ch_r2 = fb_rd_data[3*COLOR_BITS-1 -: COLOR_BITS];
    assign ch_g2 = fb_rd_data[2*COLOR_BITS-1 -: COLOR_BITS];
    assign ch_b2 = fb_rd_data[COLOR_BITS-1 -: COLOR_BITS];

    assign disp_len  = CNT_W'(BASE_ON) << plane_q;
    assign disp_last = disp_len - CNT_W'(1);
`ifdef HUB75_BRIGHTNESS_EN
    assign on_prod   = (CNT_W+8)'(disp_len) * (CNT_W+8)'(brightness);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            plane_q      <= '0;
            cnt_q        <= '0;
            row_out_q    <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            on_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            plane_q      <= plane_d;
            cnt_q        <= cnt_d;
            row_out_q    <= row_out_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
            on_q         <= on_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        plane_d      = plane_q;
        cnt_d        = cnt_q;
        row_out_d    = row_out_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
        on_d         = on_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable) state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                pix_d = {ch_r1[plane_q], ch_g1[plane_q], ch_b1[plane_q],
                         ch_r2[plane_q], ch_g2[plane_q], ch_b2[plane_q]};
                cnt_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (col_q != COL_LAST) begin
                        col_d   = col_q + 1'b1;
                        state_d = FETCH;
                    end else begin
                        col_d   = '0;
                        state_d = BLANK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                row_out_d = row_q;
                cnt_d     = '0;
                state_d   = LATCH;
            end
            LATCH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = DISPLAY;
`ifdef HUB75_BRIGHTNESS_EN
                    on_d    = on_prod[CNT_W+7:8];
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DISPLAY: begin
                // Advance happens on the last display cycle so the following state supplies the single blank cycle.
                if (cnt_q == disp_last) begin
                    cnt_d = '0;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                    state_d = enable ? FETCH : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fb_rd_en   = (state_q == FETCH);
        fb_rd_addr = {row_q, col_q};
        mclk       = (state_q == SHIFT_HI);
        lat        = (state_q == LATCH);
        oe         = 1'b1;
        if (state_q == DISPLAY) begin
`ifdef HUB75_BRIGHTNESS_EN
            oe = !(cnt_q < on_q);
`else
            oe = 1'b0;
`endif
        end
        {r1, g1, b1, r2, g2, b2} = pix_q;
        {d, c, b, a}             = 4'(row_out_q);
        frame_done               = frame_done_q;
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: frame timing, pixel capture table, enable drop and mid-scan reset.
module tb_hub75_scan_driver;

    localparam int CLK_DIV = 2;
    localparam int FRAME   = 27840;
`ifdef HUB75_BRIGHTNESS_EN
    localparam int BRIGHT  = 128;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        fb_rd_en;
    logic [8:0]  fb_rd_addr;
    logic [23:0] fb_rd_data = '0;
    logic        r1, g1, b1, r2, g2, b2, a, b, c, d, mclk, lat, oe, frame_done;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'(BRIGHT);
`endif

    always #5 clk = ~clk;

    hub75_scan_driver dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .fb_rd_en   (fb_rd_en),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_data (fb_rd_data),
        .r1 (r1), .g1 (g1), .b1 (b1), .r2 (r2), .g2 (g2), .b2 (b2),
        .a (a), .b (b), .c (c), .d (d),
        .mclk       (mclk),
        .lat        (lat),
        .oe         (oe),
        .frame_done (frame_done)
    );

    // Sparse frame-buffer image; everything not listed is black.
    function automatic logic [23:0] ram_pixel(input logic [8:0] addr);
        case (addr)
            9'd103:  return 24'hA00000;  // row 3 col 7: r1 = 1010
            9'd31:   return 24'h000006;  // row 0 col 31: b2 = 0110
            9'd63:   return 24'hFFFFFF;  // row 1 col 31: all ones
            9'd480:  return 24'h111111;  // row 15 col 0: all channels 0001
            default: return 24'h000000;
        endcase
    endfunction

    always @(posedge clk) if (fb_rd_en) fb_rd_data <= ram_pixel(fb_rd_addr);

    function automatic int exp_on(input int len);
`ifdef HUB75_BRIGHTNESS_EN
        return (len * BRIGHT) >>> 8;
`else
        return len;
`endif
    endfunction

    int n_cmp = 0;
    int n_bad = 0;
    int rel   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rel++;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return fb_rd_en == 1'b1;
            1:       return oe == 1'b0;
            2:       return frame_done == 1'b1;
            default: return oe == 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (cond(sel)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event within %0d cycles, required one", name, budget);
        end
    endtask

    // Whole-frame monitor, sampling on the falling edge.
    bit         mon_on = 0;
    int         cyc = 0, n_fetch = 0, first_fetch = 0, n_fall = 0, first_fall = 0;
    int         n_w = 0, oe_run = 0, lat_run = 0, n_lat = 0, lat_bad = 0, lat_oe_bad = 0;
    int         pre_bad = 0, abcd_oe_bad = 0, n_rise = 0, n_fd = 0, fd_cyc = 0;
    int         addr_log [32];
    int         w_log    [64];
    int         abcd_log [64];
    logic [5:0] cap      [2048];
    logic       prev_oe = 1'b1, prev_lat = 1'b0, prev_mclk = 1'b0;
    logic [3:0] prev_abcd = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            if (fb_rd_en) begin
                if (n_fetch == 0) first_fetch = cyc;
                if (n_fetch < 32) addr_log[n_fetch] = int'(fb_rd_addr);
                n_fetch++;
            end
            if (n_fetch > 0 && n_fall == 0 && {d, c, b, a} != 4'd0) pre_bad++;
            if (!oe && prev_oe) begin
                if (n_fall == 0) first_fall = cyc;
                if (n_fall < 64) abcd_log[n_fall] = int'({d, c, b, a});
                n_fall++;
            end
            if (!oe) oe_run++;
            if (oe && !prev_oe) begin
                if (n_w < 64) w_log[n_w] = oe_run;
                n_w++;
                oe_run = 0;
            end
            if (lat) begin
                lat_run++;
                if (!oe) lat_oe_bad++;
            end
            if (!lat && prev_lat) begin
                n_lat++;
                if (lat_run != CLK_DIV) lat_bad++;
                lat_run = 0;
            end
            if ({d, c, b, a} != prev_abcd && !(oe && prev_oe)) abcd_oe_bad++;
            if (mclk && !prev_mclk) begin
                if (n_rise < 2048) cap[n_rise] = {r1, g1, b1, r2, g2, b2};
                n_rise++;
            end
            if (frame_done) begin
                n_fd++;
                fd_cyc = cyc;
            end
        end
        prev_oe   = oe;
        prev_lat  = lat;
        prev_mclk = mclk;
        prev_abcd = {d, c, b, a};
    end

    typedef struct {
        int         row;
        int         col;
        int         plane;
        logic [5:0] pins;
    } pix_vec_t;

    pix_vec_t vecs [14];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int start;
        vecs[0]  = '{3, 7, 0, 6'b000000};
        vecs[1]  = '{3, 7, 1, 6'b100000};
        vecs[2]  = '{3, 7, 2, 6'b000000};
        vecs[3]  = '{3, 7, 3, 6'b100000};
        vecs[4]  = '{0, 31, 0, 6'b000000};
        vecs[5]  = '{0, 31, 1, 6'b000001};
        vecs[6]  = '{0, 31, 2, 6'b000001};
        vecs[7]  = '{0, 31, 3, 6'b000000};
        vecs[8]  = '{1, 31, 0, 6'b111111};
        vecs[9]  = '{1, 31, 3, 6'b111111};
        vecs[10] = '{15, 0, 0, 6'b111111};
        vecs[11] = '{15, 0, 1, 6'b000000};
        vecs[12] = '{3, 6, 1, 6'b000000};
        vecs[13] = '{3, 8, 3, 6'b000000};

        // Reset state
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) tick();
        check("rst_oe", int'(oe), 1);
        check("rst_lat", int'(lat), 0);
        check("rst_mclk", int'(mclk), 0);
        check("rst_fb_rd_en", int'(fb_rd_en), 0);
        check("rst_pins", int'({r1, g1, b1, r2, g2, b2}), 0);
        check("rst_abcd", int'({d, c, b, a}), 0);
        check("rst_frame_done", int'(frame_done), 0);

        // One full frame from reset
        mon_on  = 1;
        enable  = 1'b1;
        reset_n = 1'b1;
        wait_cond(2, FRAME + 400, "frame_done_wait");
        tick();
        tick();
        mon_on = 0;
        check("frame_done_count", n_fd, 1);
        check("frame_period", fd_cyc - first_fetch, FRAME);
        check("first_oe_fall", first_fall - first_fetch, 195);
        for (int i = 0; i < 32; i++) check($sformatf("fetch_addr_%0d", i), addr_log[i], i);
        check("oe_window_count", n_w, 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("oe_width_r%0d_p%0d", i / 4, i % 4), w_log[i], exp_on(64 << (i % 4)));
            check($sformatf("abcd_r%0d_p%0d", i / 4, i % 4), abcd_log[i], i / 4);
        end
        check("abcd_before_display", pre_bad, 0);
        check("lat_pulse_count", n_lat, 64);
        check("lat_width", lat_bad, 0);
        check("lat_with_oe_low", lat_oe_bad, 0);
        check("abcd_change_oe_low", abcd_oe_bad, 0);
        check("mclk_rise_count", n_rise, 2048);
        for (int i = 0; i < 14; i++) begin
            int k;
            k = ((vecs[i].row * 4 + vecs[i].plane) * 32) + vecs[i].col;
            check($sformatf("pix_r%0d_c%0d_p%0d", vecs[i].row, vecs[i].col, vecs[i].plane),
                  int'(cap[k]), int'(vecs[i].pins));
        end

        // Enable dropped while shifting plane 2 of row 0
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_cond(0, 5, "drop_first_fetch");
        rel = 0;
        while (rel < 680) tick();
        enable = 1'b0;
        wait_cond(1, 200, "drop_oe_fall");
        check("drop_oe_fall_cycle", rel, 777);
        start = rel;
        wait_cond(3, 600, "drop_oe_rise");
        check("drop_plane2_width", rel - start, exp_on(256));
        start = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fb_rd_en || !oe || mclk || lat) start++;
        end
        check("idle_quiet", start, 0);
        enable = 1'b1;
        wait_cond(0, 5, "resume_fetch");
        check("resume_addr", int'(fb_rd_addr), 0);
        rel = 0;
        wait_cond(1, 300, "resume_oe_fall");
        check("resume_oe_fall_cycle", rel, 195);
        check("resume_abcd", int'({d, c, b, a}), 0);
        start = rel;
        wait_cond(3, 1000, "resume_oe_rise");
        check("resume_plane3_width", rel - start, exp_on(512));
        check("next_row_fetch_now", int'(fb_rd_en), 1);
        check("next_row_addr", int'(fb_rd_addr), 32);

        // Reset pulse during DISPLAY of row 1
        wait_cond(1, 300, "row1_oe_fall");
        check("row1_abcd", int'({d, c, b, a}), 1);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_oe", int'(oe), 1);
        check("midrst_lat", int'(lat), 0);
        check("midrst_mclk", int'(mclk), 0);
        check("midrst_pins", int'({r1, g1, b1, r2, g2, b2}), 0);
        check("midrst_abcd", int'({d, c, b, a}), 0);
        check("midrst_fb_rd_en", int'(fb_rd_en), 0);
        reset_n = 1'b1;
        wait_cond(0, 5, "restart_fetch");
        check("restart_addr", int'(fb_rd_addr), 0);
        rel = 0;
        wait_cond(1, 300, "restart_oe_fall");
        check("restart_oe_fall_cycle", rel, 195);
        check("restart_abcd", int'({d, c, b, a}), 0);
        start = rel;
        wait_cond(3, 300, "restart_oe_rise");
        check("restart_plane0_width", rel - start, exp_on(64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
